// File: rtl/aes128_key_expand.sv
// AES-128 key schedule: streams round keys 0..10 over valid/ready.
// Ports: clk, rst_n, start, key_in -> busy, rk_valid/rk_ready, rk_index, round_key, done.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte of the packed table.
    assign y = TABLE[(11'd2047 - {a, 3'b000}) -: 8];
endmodule

module aes128_key_expand #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_index,
    output logic [127:0] round_key,
    output logic         done
);
    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    state_t       state;
    state_t       state_next;
    logic         armed;
    logic         load;
    logic         accept;
    logic         last;
    logic [7:0]   rcon;
    logic [7:0]   rcon_next;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot;
    logic [31:0]  sub;
    logic [31:0]  t;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;

    assign {w0, w1, w2, w3} = round_key;
    assign rot = {w3[23:0], w3[31:24]};

    aes_sbox u_sb0 (.a(rot[31:24]), .y(sub[31:24]));
    aes_sbox u_sb1 (.a(rot[23:16]), .y(sub[23:16]));
    aes_sbox u_sb2 (.a(rot[15:8]),  .y(sub[15:8]));
    aes_sbox u_sb3 (.a(rot[7:0]),   .y(sub[7:0]));

    assign t  = sub ^ {rcon, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    assign last = (rk_index == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // armed blocks a start that coincides with reset release;
    // done blocks a start in the completion cycle.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && armed && !done) begin
                    load       = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    accept = 1'b1;
                    if (last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            busy      <= 1'b0;
            rk_valid  <= 1'b0;
            done      <= 1'b0;
            rk_index  <= 4'd0;
            round_key <= 128'h0;
            rcon      <= 8'h01;
        end else begin
            armed    <= 1'b1;
            busy     <= (state_next == EMIT);
            rk_valid <= (state_next == EMIT);
            done     <= accept && last;
            if (load) begin
                round_key <= key_in;
                rk_index  <= 4'd0;
                rcon      <= 8'h01;
            end else if (accept && !last) begin
                round_key <= next_key;
                rk_index  <= rk_index + 4'd1;
                rcon      <= rcon_next;
            end
        end
    end
endmodule

// File: tb/tb_aes128_key_expand.sv
// Directed bench for aes128_key_expand.
// FIPS-197 A.1 and other known-answer key schedules.

module tb_aes128_key_expand;
    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_index;
    logic [127:0] round_key;
    logic         done;

    int checks;
    int failures;

    logic [127:0] fips [0:10];

    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_ONES = {128{1'b1}};

    aes128_key_expand #(.NUM_ROUNDS(10)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .key_in(key_in),
        .busy(busy),
        .rk_valid(rk_valid),
        .rk_ready(rk_ready),
        .rk_index(rk_index),
        .round_key(round_key),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input int idx,
                        input logic [127:0] exp);
        chk({tag, "_valid"}, {127'h0, rk_valid}, 128'h1);
        chk({tag, "_busy"}, {127'h0, busy}, 128'h1);
        chk({tag, "_idx"}, {124'h0, rk_index}, 128'(idx));
        chk({tag, "_key"}, round_key, exp);
    endtask

    task automatic idle_chk(input string tag, input logic exp_done);
        chk({tag, "_valid"}, {127'h0, rk_valid}, 128'h0);
        chk({tag, "_busy"}, {127'h0, busy}, 128'h0);
        chk({tag, "_done"}, {127'h0, done}, {127'h0, exp_done});
    endtask

    task automatic do_start(input logic [127:0] k);
        key_in = k;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst_n    = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b0;
        key_in   = 128'h0;
        repeat (3) tick();
        idle_chk("reset", 1'b0);
        chk("reset_idx", {124'h0, rk_index}, 128'h0);
        chk("reset_key", round_key, 128'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        // FIPS-197 vector, no backpressure
        rk_ready = 1'b1;
        do_start(K_FIPS);
        for (int i = 0; i <= 10; i++) begin
            beat("fips", i, fips[i]);
            tick();
        end
        idle_chk("fips_done", 1'b1);
        chk("fips_hold_key", round_key, fips[10]);
        tick();
        idle_chk("fips_after", 1'b0);

        // same key with 3-cycle stalls
        do_start(K_FIPS);
        for (int i = 0; i <= 10; i++) begin
            beat("bp", i, fips[i]);
            if ($urandom_range(0, 1) == 1) begin
                rk_ready = 1'b0;
                repeat (3) begin
                    tick();
                    beat("bp_stall", i, fips[i]);
                end
            end
            rk_ready = 1'b1;
            tick();
        end
        idle_chk("bp_done", 1'b1);

        // zero key; start with another key at index 3 is ignored
        tick();
        do_start(128'h0);
        for (int i = 0; i <= 10; i++) begin
            chk("zero_idx", {124'h0, rk_index}, 128'(i));
            if (i == 1)
                chk("zero_r1", round_key,
                    128'h62636363626363636263636362636363);
            if (i == 10)
                chk("zero_r10", round_key,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e);
            if (i == 3) begin
                key_in = K_ONES;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        idle_chk("zero_done", 1'b1);

        // start in the done cycle is ignored
        key_in = K_ONES;
        start  = 1'b1;
        tick();
        start = 1'b0;
        idle_chk("start_in_done", 1'b0);
        chk("start_in_done_key", round_key,
            128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // all-ones key, then async reset at index 5
        do_start(K_ONES);
        beat("ones_r0", 0, K_ONES);
        tick();
        beat("ones_r1", 1, 128'he8e9e9e917161616e8e9e9e917161616);
        repeat (4) tick();
        chk("ones_idx5", {124'h0, rk_index}, 128'd5);
        #2;
        rst_n = 1'b0;
        #1;
        idle_chk("midrst", 1'b0);
        chk("midrst_idx", {124'h0, rk_index}, 128'h0);
        chk("midrst_key", round_key, 128'h0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        idle_chk("post_rst", 1'b0);

        // fresh stream after reset
        do_start(K_FIPS);
        for (int i = 0; i <= 10; i++) begin
            beat("fresh", i, fips[i]);
            tick();
        end
        idle_chk("fresh_done", 1'b1);

        // idle hold with rk_ready toggling
        for (int i = 0; i < 20; i++) begin
            rk_ready = ~rk_ready;
            tick();
            idle_chk("idle", 1'b0);
            chk("idle_key", round_key, fips[10]);
            chk("idle_idx", {124'h0, rk_index}, 128'd10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
